// File: rtl/updown_step_sequencer.sv
// Command-driven wrap-around up/down counter: loads a value or steps a bounded
// number of counts per command, reporting completion, wraps and aborts.
module updown_step_sequencer #(
    parameter int WIDTH   = 4,
    parameter int STEPS_W = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_load,
    input  logic               cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]   cmd_value,
    input  logic               abort,
    output logic [WIDTH-1:0]   Count,
    output logic [STEPS_W-1:0] remaining,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]   CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [STEPS_W-1:0] STEP_ONE  = STEPS_W'(1);
    localparam logic [STEPS_W-1:0] STEP_ZERO = {STEPS_W{1'b0}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [STEPS_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               aborted_q, aborted_d;
    logic               wrap_q, wrap_d;

    // State and datapath registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= CNT_ZERO;
            rem_q     <= STEP_ZERO;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state and datapath update; wrap is a single-cycle pulse by default.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;
        wrap_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    aborted_d = 1'b0;
                    if (cmd_load) begin
                        count_d = cmd_value;
                        state_d = ST_DONE;
                    end else if (cmd_steps == STEP_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = cmd_steps;
                        dir_d   = cmd_dir;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins even over the final step.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    if (dir_q) begin
                        count_d = count_q + CNT_ONE;
                        wrap_d  = (count_q == CNT_MAX);
                    end else begin
                        count_d = count_q - CNT_ONE;
                        wrap_d  = (count_q == CNT_ZERO);
                    end
                    rem_d = rem_q - STEP_ONE;
                    if (rem_q == STEP_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Count     = count_q;
    assign remaining = rem_q;
    assign aborted   = aborted_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_updown_step_sequencer.sv
// Scoreboard bench: the driver predicts each command's outcome arithmetically
// and queues it; an independent monitor checks it when done pulses.
module tb_updown_step_sequencer;

    localparam int WIDTH   = 4;
    localparam int STEPS_W = 8;
    localparam int MOD     = 1 << WIDTH;

    logic               Clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_load = 1'b0;
    logic               cmd_dir = 1'b0;
    logic [STEPS_W-1:0] cmd_steps = '0;
    logic [WIDTH-1:0]   cmd_value = '0;
    logic               abort = 1'b0;
    logic [WIDTH-1:0]   Count;
    logic [STEPS_W-1:0] remaining;
    logic               busy, done, aborted, wrap;

    updown_step_sequencer #(.WIDTH(WIDTH), .STEPS_W(STEPS_W)) dut (
        .Clk(Clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .cmd_value(cmd_value), .abort(abort), .Count(Count), .remaining(remaining),
        .busy(busy), .done(done), .aborted(aborted), .wrap(wrap)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int count;
        int rem;
        int abrt;
        int wraps;
        int done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   wrap_seen = 0;
    int   m_count = 0;
    int   m_rem = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: compares each done pulse against the oldest prediction.
    always @(negedge Clk) begin
        exp_t e;
        if (!reset) begin
            wrap_seen = 0;
        end else begin
            chk("ready_vs_busy", int'(cmd_ready), int'(!busy));
            if (wrap) wrap_seen++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_count", int'(Count), e.count);
                    chk("done_remaining", int'(remaining), e.rem);
                    chk("done_aborted", int'(aborted), e.abrt);
                    chk("done_wraps", wrap_seen, e.wraps);
                    chk("done_cycle", cyc, e.done_cyc);
                end
                wrap_seen = 0;
            end
        end
    end

    // Drive one command, predict its outcome, optionally abort on RUN edge abort_k.
    task automatic issue(input bit ld, input bit dir, input int steps, input int val,
                         input int abort_k);
        exp_t e;
        int   n = 0;
        int   k;
        int   taken;
        int   acc;
        k = (ld || steps == 0 || abort_k > steps) ? 0 : abort_k;
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_dir   = dir;
        cmd_steps = steps[STEPS_W-1:0];
        cmd_value = val[WIDTH-1:0];
        while (!cmd_ready && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        cmd_load  = $urandom_range(0, 1);
        cmd_steps = STEPS_W'($urandom_range(0, 255));
        acc = cyc;
        if (ld) begin
            m_count = val % MOD;
            e = '{m_count, m_rem, 0, 0, acc};
        end else if (steps == 0) begin
            e = '{m_count, m_rem, 0, 0, acc};
        end else begin
            taken = (k > 0) ? k - 1 : steps;
            e.wraps = 0;
            if (dir) begin
                e.wraps = (m_count + taken) / MOD;
                m_count = (m_count + taken) % MOD;
            end else begin
                if (taken > m_count) e.wraps = (taken - m_count - 1) / MOD + 1;
                m_count = ((m_count - taken) % MOD + MOD) % MOD;
            end
            m_rem      = steps - taken;
            e.count    = m_count;
            e.rem      = m_rem;
            e.abrt     = (k > 0) ? 1 : 0;
            e.done_cyc = acc + ((k > 0) ? k : steps);
        end
        exp_q.push_back(e);
        if (k > 0) begin
            repeat (k - 1) begin
                @(posedge Clk);
                #1;
            end
            abort = 1'b1;
            @(posedge Clk);
            #1;
            abort = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge Clk);
            n++;
        end
        repeat (2) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, int'(Count), 0);
        chk({tag, "_remaining"}, int'(remaining), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        // Reset with a load command pending: must not be accepted.
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_value = 4'd9;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_reset_outputs("reset");
        cmd_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("post_reset_count", int'(Count), 0);

        // Directed scenarios.
        issue(1'b1, 1'b0, 0, 14, 0);
        issue(1'b0, 1'b1, 3, 0, 0);
        issue(1'b1, 1'b0, 0, 1, 0);
        issue(1'b0, 1'b0, 4, 0, 0);
        issue(1'b1, 1'b0, 0, 5, 0);
        issue(1'b0, 1'b1, 6, 0, 3);
        issue(1'b0, 1'b1, 0, 0, 0);
        issue(1'b0, 1'b0, 0, 0, 0);
        issue(1'b0, 1'b0, 1, 0, 1);
        issue(1'b0, 1'b1, 2, 0, 2);
        wait_drained();

        // Randomized commands with random idle gaps and ignored idle aborts.
        for (int i = 0; i < 80; i++) begin
            int r;
            int st;
            r  = $urandom_range(0, 99);
            st = $urandom_range(1, 40);
            if (r < 20)      issue(1'b1, 1'($urandom_range(0, 1)), st, $urandom_range(0, MOD - 1), 0);
            else if (r < 32) issue(1'b0, 1'($urandom_range(0, 1)), 0, 0, 0);
            else if (r < 55) issue(1'b0, 1'($urandom_range(0, 1)), st, 0, $urandom_range(1, st));
            else             issue(1'b0, 1'($urandom_range(0, 1)), st, 0, 0);
            if ($urandom_range(0, 4) == 0) begin
                wait_drained();
                abort = 1'b1;
                repeat (2) @(negedge Clk);
                abort = 1'b0;
                chk("idle_abort_ignored_busy", int'(busy), 0);
            end
        end
        wait_drained();

        // Reset in the middle of a long run.
        issue(1'b1, 1'b0, 0, 0, 0);
        wait_drained();
        issue(1'b0, 1'b1, 200, 0, 0);
        repeat (10) @(posedge Clk);
        #1;
        chk("midrun_count_before", int'(Count), 10);
        reset = 1'b0;
        #1;
        exp_q.delete();
        m_count = 0;
        m_rem   = 0;
        chk_reset_outputs("midrun_reset");
        @(negedge Clk);
        reset = 1'b1;
        issue(1'b0, 1'b1, 2, 0, 0);
        wait_drained();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/updown_step_sequencer.md
# updown_step_sequencer

Command-driven sequencer that owns a WIDTH-bit wrap-around up/down counter and steps it a programmed number of counts in a chosen direction. Commands arrive on a valid/ready handshake. The block reports completion, wrap events and aborts. It sits between control logic (button decoders, test FSMs) and any consumer of the count value, replacing free-running counting with bounded, observable moves.

## Interface
- WIDTH, 4, count width; the count wraps modulo 2^WIDTH.
- STEPS_W, 8, width of the step-count field in a command.
- Clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
- cmd_load  input  1  1 = load cmd_value into Count; 0 = step command.
- cmd_dir  input  1  step direction: 1 = up, 0 = down.
- cmd_steps  input  STEPS_W  number of steps, unsigned.
- cmd_value  input  WIDTH  load value.
- abort  input  1  terminate a running step command.
- Count  output  WIDTH  current count value, registered.
- remaining  output  STEPS_W  steps still to take, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at command completion.
- aborted  output  1  qualifies done: 1 = command ended by abort; 0 otherwise.
- wrap  output  1  one-cycle pulse in the cycle Count shows a wrapped value.

## Operation
- States: IDLE, RUN, DONE.
- Reset (reset low, any state):
  - state = IDLE; Count = 0; remaining = 0; done = 0; aborted = 0; wrap = 0; busy = 0; cmd_ready = 1.
  - No command is accepted while reset is low.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready.
- IDLE, accepted command:
  - cmd_load = 1: Count <= cmd_value; go to DONE. cmd_dir and cmd_steps are ignored.
  - cmd_load = 0, cmd_steps = 0: go to DONE; Count is unchanged.
  - cmd_load = 0, cmd_steps != 0: latch cmd_dir; remaining <= cmd_steps; go to RUN.
- RUN, each cycle without abort, one step:
  - Up: Count 2^WIDTH-1 -> 0, else Count + 1.
  - Down: Count 0 -> 2^WIDTH-1, else Count - 1.
  - remaining <= remaining - 1.
  - When remaining == 1 at the step, go to DONE.
- RUN with abort high: no step that cycle; remaining is held; aborted <= 1; go to DONE. Abort takes priority over a simultaneous final step.
- DONE: done = 1 for exactly one cycle; cmd_ready = 0; next state IDLE. The aborted flag is cleared on the next accepted command.
- wrap: registered; high in the cycle Count holds the value produced by a wrapping step. Loads never raise wrap.
- abort in IDLE or DONE is ignored.
- cmd_* inputs are don't-care unless cmd_valid && cmd_ready.

## Timing
- Step command with N >= 1 accepted at edge T:
  - Steps occur at edges T+1 .. T+N.
  - done is high during the cycle after edge T+N.
  - cmd_ready returns after edge T+N+1.
  - Throughput: N+2 cycles per command.
- Load command, or step command with N = 0, accepted at edge T:
  - Count is updated at edge T (load only).
  - done is high in the cycle after T.
  - Next accept is possible at edge T+2.
- Abort sampled at edge A in RUN: Count holds its value from A-1; done and aborted are high in the cycle after A.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset asserted mid-RUN: all outputs go to reset values immediately, with no done pulse.

## Test plan
- Reset: hold reset low 3 cycles -> Count = 0, busy = 0, done = 0, wrap = 0, cmd_ready = 1; cmd_valid during reset is not accepted.
- Up wrap: load 14, then up with steps = 3 -> Count 15, 0, 1 on consecutive cycles; wrap pulses with Count = 0; done one cycle after Count = 1, aborted = 0.
- Down wrap: load 1, then down with steps = 4 -> Count 0, 15, 14, 13; wrap pulses with Count = 15; remaining ends at 0.
- Abort: from Count = 5, up with steps = 6, abort on the third RUN edge -> Count stops at 7; done = 1 and aborted = 1 together; remaining = 4.
- Zero steps and back-to-back commands: steps = 0 -> done next cycle, Count unchanged. A command held valid through DONE -> accepted exactly once, at the first IDLE edge.
- Reset mid-run: up with steps = 200 from 0, reset low after 10 steps -> Count = 0, state IDLE, no done pulse; a fresh up 2-step command afterwards -> Count 1, 2.
